// File: rtl/reg_file_pkg.sv
// Shared MIPS register-file constants: architectural register indices and default widths.
// Imported by the register file, its read ports, and the control/decode blocks.
package reg_file_pkg;
    localparam int REG_ZERO   = 0;
    localparam int REG_SP     = 29;
    localparam int REG_RA     = 31;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: forces index 0 to zero, optionally forwards same-cycle write data.
// Latency 0; no backpressure.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_byp_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_stored,
    input  logic              i_wr_vld,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);
    logic w_is_zero;
    logic w_hit;

    assign w_is_zero = (i_rd_addr == ADDR_W'(REG_ZERO));
    // i_wr_vld already excludes reset and writes to index 0
    assign w_hit     = i_byp_en && i_wr_vld && (i_rd_addr == i_wr_addr);

    always_comb begin
        o_rd_data = i_stored;
        if (w_is_zero)
            o_rd_data = '0;
        else if (w_hit)
            o_rd_data = i_wr_data;
    end
endmodule

// File: rtl/reg_file.sv
// 32x32 MIPS register file: two operand read ports (optional bypass), one write port, one debug port.
// Read latency 0, write latency 1; no handshake, one write per cycle.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int              DATA_W  = DEF_DATA_W,
    parameter int              ADDR_W  = DEF_ADDR_W,
    parameter bit              BYPASS  = 1'b1,
    parameter logic [DATA_W-1:0] SP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Register 0 has no storage; the read ports return zero for it.
    logic [DATA_W-1:0] r_regs [1:DEPTH-1];

    logic              w_wr_vld;
    logic [DATA_W-1:0] w_stored1;
    logic [DATA_W-1:0] w_stored2;
    logic [DATA_W-1:0] w_stored_dbg;

    assign w_wr_vld = !rst && wr_en && (wr_addr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++)
                r_regs[i] <= (i == REG_SP) ? SP_INIT : '0;
        end else if (w_wr_vld) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        w_stored1    = '0;
        w_stored2    = '0;
        w_stored_dbg = '0;
        if (rd_addr1 != ADDR_W'(REG_ZERO)) w_stored1    = r_regs[rd_addr1];
        if (rd_addr2 != ADDR_W'(REG_ZERO)) w_stored2    = r_regs[rd_addr2];
        if (dbg_addr != ADDR_W'(REG_ZERO)) w_stored_dbg = r_regs[dbg_addr];
    end

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
        .i_byp_en  (BYPASS),
        .i_rd_addr (rd_addr1),
        .i_stored  (w_stored1),
        .i_wr_vld  (w_wr_vld),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .o_rd_data (rd_data1)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
        .i_byp_en  (BYPASS),
        .i_rd_addr (rd_addr2),
        .i_stored  (w_stored2),
        .i_wr_vld  (w_wr_vld),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .o_rd_data (rd_data2)
    );

    // Debug/trace view must show architectural state only, so forwarding is off.
    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg (
        .i_byp_en  (1'b0),
        .i_rd_addr (dbg_addr),
        .i_stored  (w_stored_dbg),
        .i_wr_vld  (w_wr_vld),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .o_rd_data (dbg_data)
    );
endmodule
